// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer for the lab MIPS core: owns the PC, issues imem requests and hands instructions to decode.
// Optional build macro PC_ALIGN_CHECK_EN enables the sticky align_err flag for misaligned jump-register targets.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_type,
    input  logic [31:0] redirect_base_pc,
    input  logic [15:0] branch_offset,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic [31:0] current_pc,
    output logic        align_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        redir_ok;
    logic [31:0] seq_pc;
    logic [31:0] redir_target;

    assign redir_ok = redirect_valid && (redirect_type != 2'b11);

    // Jump-register targets always have their low two bits cleared so the PC stays word-aligned.
    always_comb begin
        seq_pc       = redirect_base_pc + 32'd4;
        redir_target = seq_pc;
        case (redirect_type)
            2'b00:   redir_target = seq_pc + {{14{branch_offset[15]}}, branch_offset, 2'b00};
            2'b01:   redir_target = {seq_pc[31:28], instr_index, 2'b00};
            2'b10:   redir_target = {jr_target[31:2], 2'b00};
            default: redir_target = seq_pc;
        endcase
    end

    assign imem_addr  = pc_q;
    assign current_pc = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc_q        <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    // An outstanding request is never aborted; a redirect only takes effect once it is acked.
                    if (imem_ack) begin
                        if (redir_ok) begin
                            pc_q       <= redir_target;
                            pend_valid <= 1'b0;
                        end else if (pend_valid) begin
                            pc_q       <= pend_target;
                            pend_valid <= 1'b0;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc_q;
                            state       <= HOLD;
                            imem_req    <= 1'b0;
                            instr_valid <= 1'b1;
                        end
                    end else if (redir_ok) begin
                        pend_valid  <= 1'b1;
                        pend_target <= redir_target;
                    end
                end
                HOLD: begin
                    if (redir_ok) begin
                        pc_q        <= redir_target;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end else if (instr_ready) begin
                        pc_q        <= instr_pc + 32'd4;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            align_err <= 1'b0;
        end else if ((state != IDLE) && redirect_valid && (redirect_type == 2'b10)
                     && (jr_target[1:0] != 2'b00)) begin
            align_err <= 1'b1;
        end
    end
`else
    logic unused_jr_low;
    assign unused_jr_low = ^jr_target[1:0];
    assign align_err     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by randomized traffic,
// all compared against a transaction-level reference model of the fetch sequencer.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [1:0]  redirect_type;
    logic [31:0] redirect_base_pc;
    logic [15:0] branch_offset;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic [31:0] current_pc;
    logic        align_err;

    int n_checks = 0;
    int n_passed = 0;

    pc_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_type(redirect_type),
        .redirect_base_pc(redirect_base_pc), .branch_offset(branch_offset),
        .instr_index(instr_index), .jr_target(jr_target),
        .current_pc(current_pc), .align_err(align_err)
    );

    always #5 clk = ~clk;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif

    // Model state: phase of the sequencer plus the architectural values it should expose.
    bit          m_starting;
    bit          m_holding;
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_tgt;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_err;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] modelTarget(input logic [1:0] t, input logic [31:0] base,
                                                input logic [15:0] off, input logic [25:0] idx,
                                                input logic [31:0] jr);
        logic signed [31:0] soff;
        soff = $signed(off);
        case (t)
            2'd0:    return base + 32'd4 + $unsigned(soff * 4);
            2'd1:    return ((base + 32'd4) & 32'hF000_0000) | ({6'd0, idx} << 2);
            default: return jr & 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
        else
            n_passed++;
    endtask

    // Drives one cycle of inputs, advances the model across the clock edge and compares at the next negedge.
    task automatic applyStimulus(input logic s_rst, input logic s_ack, input logic s_ready,
                                 input logic s_rv, input logic [1:0] s_rt, input logic [31:0] s_base,
                                 input logic [15:0] s_off, input logic [25:0] s_idx, input logic [31:0] s_jr);
        logic [31:0] tgt;
        bit          take;
        rst              = s_rst;
        imem_ack         = s_ack;
        imem_rdata       = s_ack ? memWord(imem_addr) : $urandom;
        instr_ready      = s_ready;
        redirect_valid   = s_rv;
        redirect_type    = s_rt;
        redirect_base_pc = s_base;
        branch_offset    = s_off;
        instr_index      = s_idx;
        jr_target        = s_jr;

        tgt  = modelTarget(s_rt, s_base, s_off, s_idx, s_jr);
        take = s_rv && (s_rt != 2'b11);
        if (s_rst) begin
            m_starting = 1; m_holding = 0; m_pc = RESET_PC; m_pend = 0;
            m_pend_tgt = 0; m_instr = 0; m_ipc = 0; m_err = 0;
        end else if (m_starting) begin
            m_starting = 0;
        end else begin
            if (ALIGN_CHECK && s_rv && s_rt == 2'b10 && (s_jr % 4) != 0) m_err = 1;
            if (!m_holding) begin
                if (s_ack && (take || m_pend)) begin
                    m_pc   = take ? tgt : m_pend_tgt;
                    m_pend = 0;
                end else if (s_ack) begin
                    m_instr   = memWord(m_pc);
                    m_ipc     = m_pc;
                    m_holding = 1;
                end else if (take) begin
                    m_pend     = 1;
                    m_pend_tgt = tgt;
                end
            end else if (take) begin
                m_pc = tgt; m_holding = 0;
            end else if (s_ready) begin
                m_pc = m_ipc + 32'd4; m_holding = 0;
            end
        end

        @(negedge clk);
        checkOutput("imem_req", {31'd0, imem_req}, {31'd0, !m_starting && !m_holding});
        checkOutput("instr_valid", {31'd0, instr_valid}, {31'd0, m_holding});
        checkOutput("imem_addr", imem_addr, m_pc);
        checkOutput("current_pc", current_pc, m_pc);
        checkOutput("instr", instr, m_instr);
        checkOutput("instr_pc", instr_pc, m_ipc);
        checkOutput("align_err", {31'd0, align_err}, {31'd0, m_err});
    endtask

    task automatic idleCycle(input logic a, input logic r);
        applyStimulus(1'b0, a, r, 1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
    endtask

    task automatic redirectCycle(input logic [1:0] t, input logic [31:0] base, input logic [15:0] off,
                                 input logic [25:0] idx, input logic [31:0] jr, input logic a, input logic r);
        applyStimulus(1'b0, a, r, 1'b1, t, base, off, idx, jr);
    endtask

    initial begin
        // Reset and strictly sequential fetch with a one-cycle ack latency.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
        checkOutput("reset_pc", current_pc, RESET_PC);
        checkOutput("reset_req", {31'd0, imem_req}, 32'd0);
        idleCycle(1'b0, 1'b1);
        checkOutput("first_req", {31'd0, imem_req}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("seq_addr", imem_addr, 32'(4 * k));
            idleCycle(1'b0, 1'b1);
            idleCycle(1'b1, 1'b1);
            checkOutput("seq_instr_pc", instr_pc, 32'(4 * k));
            idleCycle(1'b0, 1'b1);
        end

        // Decode stalls for three cycles.
        idleCycle(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idleCycle(1'b0, 1'b0);
            checkOutput("stall_req_low", {31'd0, imem_req}, 32'd0);
            checkOutput("stall_instr_pc", instr_pc, 32'h10);
        end
        idleCycle(1'b0, 1'b1);
        checkOutput("after_stall_addr", imem_addr, 32'h14);

        // J-type jump while holding an instruction.
        idleCycle(1'b1, 1'b0);
        redirectCycle(2'b01, 32'h0040_0010, 16'h0, 26'h000_1234, 32'h0, 1'b0, 1'b0);
        checkOutput("jump_addr", imem_addr, 32'h0000_48D0);
        checkOutput("jump_drop", {31'd0, instr_valid}, 32'd0);

        // Branch during an outstanding fetch whose ack is late by two cycles.
        redirectCycle(2'b00, 32'h0000_0100, 16'hFFFE, 26'h0, 32'h0, 1'b0, 1'b1);
        idleCycle(1'b0, 1'b1);
        idleCycle(1'b0, 1'b1);
        idleCycle(1'b1, 1'b1);
        checkOutput("branch_addr", imem_addr, 32'h0000_00FC);
        checkOutput("branch_discard", {31'd0, instr_valid}, 32'd0);

        // Two pending redirects: the later one wins.
        redirectCycle(2'b10, 32'h0, 16'h0, 26'h0, 32'h0000_0300, 1'b0, 1'b0);
        redirectCycle(2'b10, 32'h0, 16'h0, 26'h0, 32'h0000_0400, 1'b0, 1'b0);
        idleCycle(1'b1, 1'b0);
        checkOutput("latest_wins", imem_addr, 32'h0000_0400);

        // Misaligned jump-register target.
        idleCycle(1'b1, 1'b0);
        redirectCycle(2'b10, 32'h0, 16'h0, 26'h0, 32'h0000_2002, 1'b0, 1'b0);
        checkOutput("jr_addr", imem_addr, 32'h0000_2000);
        checkOutput("jr_align_err", {31'd0, align_err}, {31'd0, ALIGN_CHECK});

        // Reserved redirect type is ignored.
        idleCycle(1'b1, 1'b0);
        redirectCycle(2'b11, 32'h0, 16'h0, 26'h0, 32'h0000_5000, 1'b0, 1'b0);
        checkOutput("reserved_hold", {31'd0, instr_valid}, 32'd1);
        idleCycle(1'b0, 1'b1);
        checkOutput("reserved_next", imem_addr, 32'h0000_2004);

        // Coincident redirect on ack, then sequential wrap past the top of memory.
        redirectCycle(2'b10, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b1, 1'b0);
        idleCycle(1'b1, 1'b0);
        checkOutput("wrap_hold_pc", instr_pc, 32'hFFFF_FFFC);
        idleCycle(1'b0, 1'b1);
        checkOutput("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset while holding, with an ack landing in the reset cycle and one more in IDLE.
        idleCycle(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
        checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_align_err", {31'd0, align_err}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
        checkOutput("rst_refetch_req", {31'd0, imem_req}, 32'd1);
        checkOutput("rst_refetch_addr", imem_addr, RESET_PC);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom % 100) == 0,
                          imem_req && ($urandom % 2 == 0),
                          ($urandom % 2) == 0,
                          ($urandom % 100) < 15,
                          2'($urandom % 4),
                          $urandom, 16'($urandom), 26'($urandom), $urandom);
        end

        $display("[TB] %0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
